lcd_spi_master: RTL and testbench
=================================

Name: lcd_spi_master

Overview:
- Parametrised SPI master that drives the LCD pins (lcd_dcn, lcd_mosi, lcd_sck, lcd_cen) from a CPU-side load/busy interface.
- Sits between the memory-mapped LCD register decode and the top-level LCD pins.
- Frame length is selectable per transfer, up to DATA_W bits. The SCK rate is set by a divider.
- Chip-enable can be held low across frames for burst pixel writes. The data/command line is latched per frame.

Parameters:
- DATA_W, 16, maximum bits per frame (>=2).
- DIV, 4, SCK half-period in clk cycles (>=1).
- LEN_W, $clog2(DATA_W), width of the len field.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- load  in  1  start request; sampled only when busy=0
- data  in  DATA_W  frame payload; bits [len:0] are sent MSB-first
- len  in  LEN_W  frame bit count minus 1
- dc  in  1  value driven on lcd_dcn for this frame (0 = command, 1 = data)
- keep_cs  in  1  1 = leave lcd_cen low after this frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes
- lcd_dcn  out  1  LCD data/command-not
- lcd_mosi  out  1  SPI data out
- lcd_sck  out  1  SPI clock, mode 0 (idle low, target samples on rising edge)
- lcd_cen  out  1  LCD chip enable, active low

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high.
  - On reset: lcd_cen=1, lcd_sck=0, lcd_mosi=0, lcd_dcn=1, busy=0, done=0, all counters 0, state IDLE.
  - Reset mid-frame aborts the frame immediately. No done pulse is produced.
- States: IDLE, LOW, HIGH, TAIL, GAP.
- Divider: one divider counter runs 0..DIV-1 in every timed state. A state exits on the cycle the counter reaches DIV-1.
- IDLE:
  - If load=1, latch data, len, dc and keep_cs.
  - Len values >= DATA_W clamp to DATA_W-1.
  - Next edge: busy=1, lcd_cen=0, lcd_dcn=dc, lcd_mosi=data[len], bitcnt=len, go to LOW.
- LOW: lcd_sck=0 for DIV cycles, then lcd_sck<=1 and go to HIGH.
- HIGH: lcd_sck=1 for DIV cycles, then lcd_sck<=0.
  - If bitcnt=0, go to TAIL.
  - Otherwise bitcnt<=bitcnt-1, lcd_mosi<=next lower bit, go to LOW.
  - lcd_mosi changes only on the falling SCK edge.
- TAIL: SCK low for DIV cycles (hold after the last falling edge).
  - If keep_cs=1: lcd_cen stays 0, go to IDLE.
  - If keep_cs=0: lcd_cen<=1, go to GAP.
- GAP: lcd_cen=1 for DIV cycles (minimum CS-high time), then go to IDLE.
- Completion:
  - On entry to IDLE: busy<=0 and done<=1 for exactly one cycle.
  - A load presented in the done cycle is accepted. This gives back-to-back frames with no extra idle cycle.
- Busy-time latency: load sampled at edge 0. Busy stays high for 2*DIV*(len+1) + DIV cycles, plus DIV more if keep_cs=0.
- Line timing:
  - The first SCK rising edge occurs DIV cycles after lcd_cen falls.
  - Exactly len+1 rising edges occur per frame.
- load while busy=1 is ignored entirely. Latched values are unaffected.
- Between keep_cs frames:
  - lcd_cen remains 0.
  - lcd_dcn may change at the next accepted load, always while SCK is low.
  - lcd_dcn and lcd_mosi hold their last values while in IDLE.
- After a keep_cs=1 frame, lcd_cen stays low indefinitely until a later frame with keep_cs=0 completes its GAP, or until reset.

Test Plan:
- DIV=2; load data=0x2A, len=7, dc=0, keep_cs=0.
  -> lcd_dcn=0; 8 SCK rises sample 0,0,1,0,1,0,1,0.
  -> busy high 36 cycles; lcd_cen high 2 cycles before done; done pulses once.
- DIV=1; frame 0xF81F, len=15, dc=1, keep_cs=1, then a second load on the done cycle with 0x07E0, keep_cs=0.
  -> lcd_cen never rises between frames.
  -> 32 SCK rises carry both words MSB-first.
  -> second busy period = 34 cycles.
- Repeated load=1 with a different data value during the first frame.
  -> that frame's bits unchanged; exactly one done; no second frame started.
- Reset asserted during the 3rd HIGH phase of a frame.
  -> immediately lcd_cen=1, lcd_sck=0, busy=0, no done.
  -> a subsequent load sends a complete, correct frame.
- len=0, data bit0=1, DIV=3, keep_cs=0.
  -> single SCK rise with lcd_mosi=1; busy high 12 cycles.
- DATA_W=12 (LEN_W=4), len=15.
  -> clamped to 12 bits (data[11] first); 12 SCK rises.

Source files
------------

// File: rtl/lcd_spi_master.sv
// SPI mode-0 master for the LCD pins: one frame of up to DATA_W bits per load,
// with the chip-enable optionally held low across frames for burst writes.
module lcd_spi_master #(
    parameter int DATA_W = 16,
    parameter int DIV    = 4,
    parameter int LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    input  logic              dc,
    input  logic              keep_cs,
    output logic              busy,
    output logic              done,
    output logic              lcd_dcn,
    output logic              lcd_mosi,
    output logic              lcd_sck,
    output logic              lcd_cen
);

    localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_TAIL = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t              state_r,   state_s;
    logic [DIV_CW-1:0]   div_cnt_r, div_cnt_s;
    logic [LEN_W-1:0]    bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0]   data_r,    data_s;
    logic                keep_cs_r, keep_cs_s;
    logic                busy_r,    busy_s;
    logic                done_r,    done_s;
    logic                dcn_r,     dcn_s;
    logic                mosi_r,    mosi_s;
    logic                sck_r,     sck_s;
    logic                cen_r,     cen_s;
    logic                div_last_s;
    logic [LEN_W-1:0]    len_clamp_s;

    // Lengths beyond the payload width would index past the top bit.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (int'(l) >= DATA_W) begin
            r = LEN_MAX;
        end else begin
            r = l;
        end
        return r;
    endfunction

    assign len_clamp_s = clamp_len(len);
    assign div_last_s  = (div_cnt_r == DIV_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        div_cnt_s = div_last_s ? {DIV_CW{1'b0}} : (div_cnt_r + DIV_CW'(1));
        bit_cnt_s = bit_cnt_r;
        data_s    = data_r;
        keep_cs_s = keep_cs_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        dcn_s     = dcn_r;
        mosi_s    = mosi_r;
        sck_s     = sck_r;
        cen_s     = cen_r;
        case (state_r)
            ST_IDLE: begin
                div_cnt_s = {DIV_CW{1'b0}};
                if (load) begin
                    state_s   = ST_LOW;
                    data_s    = data;
                    keep_cs_s = keep_cs;
                    bit_cnt_s = len_clamp_s;
                    busy_s    = 1'b1;
                    cen_s     = 1'b0;
                    dcn_s     = dc;
                    mosi_s    = data[len_clamp_s];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (div_last_s) begin
                    sck_s   = 1'b1;
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (div_last_s) begin
                    sck_s = 1'b0;
                    // MOSI only moves together with the falling SCK edge.
                    if (bit_cnt_r == {LEN_W{1'b0}}) begin
                        state_s = ST_TAIL;
                    end else begin
                        bit_cnt_s = bit_cnt_r - LEN_W'(1);
                        mosi_s    = data_r[bit_cnt_r - LEN_W'(1)];
                        state_s   = ST_LOW;
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_TAIL: begin
                if (div_last_s) begin
                    if (keep_cs_r) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        cen_s   = 1'b1;
                        state_s = ST_GAP;
                    end
                end else begin
                    state_s = ST_TAIL;
                end
            end
            ST_GAP: begin
                if (div_last_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                div_cnt_s = {DIV_CW{1'b0}};
                busy_s    = 1'b0;
                sck_s     = 1'b0;
                cen_s     = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= {DIV_CW{1'b0}};
            bit_cnt_r <= {LEN_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            keep_cs_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dcn_r     <= 1'b1;
            mosi_r    <= 1'b0;
            sck_r     <= 1'b0;
            cen_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            div_cnt_r <= div_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            data_r    <= data_s;
            keep_cs_r <= keep_cs_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            dcn_r     <= dcn_s;
            mosi_r    <= mosi_s;
            sck_r     <= sck_s;
            cen_r     <= cen_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign lcd_dcn  = dcn_r;
    assign lcd_mosi = mosi_r;
    assign lcd_sck  = sck_r;
    assign lcd_cen  = cen_r;

endmodule

// File: tb/tb_lcd_spi_master.sv
// Directed bench for lcd_spi_master: four instances cover DIV=2/1/3 and a
// 12-bit payload; a per-cycle monitor records SCK-rise bits and line activity.
module tb_lcd_spi_master;

    logic        clk;
    logic        reset;
    logic [3:0]  load;
    logic [15:0] data;
    logic [3:0]  len;
    logic        dc;
    logic        keep_cs;
    logic [3:0]  busy, done, dcn, mosi, sck, cen;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc_n;
    int          ncap[4], nbusy[4], ndone[4], ncenhi[4], ncenrise[4], nviol[4];
    int          first_dly[4], t_start[4];
    logic [63:0] cap[4];
    logic [3:0]  sck_p, cen_p, busy_p, mosi_p;
    int          nb1;

    lcd_spi_master #(.DATA_W(16), .DIV(2)) u_div2 (
        .clk(clk), .reset(reset), .load(load[0]), .data(data), .len(len), .dc(dc),
        .keep_cs(keep_cs), .busy(busy[0]), .done(done[0]), .lcd_dcn(dcn[0]),
        .lcd_mosi(mosi[0]), .lcd_sck(sck[0]), .lcd_cen(cen[0]));

    lcd_spi_master #(.DATA_W(16), .DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .load(load[1]), .data(data), .len(len), .dc(dc),
        .keep_cs(keep_cs), .busy(busy[1]), .done(done[1]), .lcd_dcn(dcn[1]),
        .lcd_mosi(mosi[1]), .lcd_sck(sck[1]), .lcd_cen(cen[1]));

    lcd_spi_master #(.DATA_W(16), .DIV(3)) u_div3 (
        .clk(clk), .reset(reset), .load(load[2]), .data(data), .len(len), .dc(dc),
        .keep_cs(keep_cs), .busy(busy[2]), .done(done[2]), .lcd_dcn(dcn[2]),
        .lcd_mosi(mosi[2]), .lcd_sck(sck[2]), .lcd_cen(cen[2]));

    lcd_spi_master #(.DATA_W(12), .DIV(2)) u_w12 (
        .clk(clk), .reset(reset), .load(load[3]), .data(data[11:0]), .len(len), .dc(dc),
        .keep_cs(keep_cs), .busy(busy[3]), .done(done[3]), .lcd_dcn(dcn[3]),
        .lcd_mosi(mosi[3]), .lcd_sck(sck[3]), .lcd_cen(cen[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 4; k++) begin
            ncap[k] = 0; nbusy[k] = 0; ndone[k] = 0; ncenhi[k] = 0;
            ncenrise[k] = 0; nviol[k] = 0; first_dly[k] = -1; t_start[k] = 0;
            cap[k] = 64'd0;
        end
        sck_p = sck; cen_p = cen; busy_p = busy; mosi_p = mosi;
    endtask

    task automatic sample();
        cyc_n++;
        for (int k = 0; k < 4; k++) begin
            if (busy[k] && !busy_p[k]) t_start[k] = cyc_n;
            if (sck[k] && !sck_p[k]) begin
                if (ncap[k] == 0) first_dly[k] = cyc_n - t_start[k];
                cap[k] = {cap[k][62:0], mosi[k]};
                ncap[k]++;
            end
            if (sck[k] && sck_p[k] && (mosi[k] !== mosi_p[k])) nviol[k]++;
            if (busy[k]) nbusy[k]++;
            if (done[k]) ndone[k]++;
            if (cen[k] && busy[k]) ncenhi[k]++;
            if (cen[k] && !cen_p[k]) ncenrise[k]++;
        end
        sck_p = sck; cen_p = cen; busy_p = busy; mosi_p = mosi;
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_done(input int k, input int budget);
        int n0;
        n0 = ndone[k];
        for (int i = 0; i < budget && ndone[k] == n0; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc_n = 0;
        reset = 1'b1; load = 4'd0; data = 16'd0; len = 4'd0; dc = 1'b0; keep_cs = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("reset_state%0d", k),
                      {58'd0, cen[k], sck[k], mosi[k], dcn[k], busy[k], done[k]}, 64'b100100);
        reset = 1'b0;
        cyc();

        // DIV=2 command byte 0x2A, CS released after frame
        clear_mon();
        data = 16'h002A; len = 4'd7; dc = 1'b0; keep_cs = 1'b0; load[0] = 1'b1;
        cyc();
        load[0] = 1'b0;
        check_val("t1_dcn", dcn[0], 64'd0);
        check_val("t1_cen_low", cen[0], 64'd0);
        wait_done(0, 200);
        repeat (4) cyc();
        check_val("t1_bits", cap[0], 64'h2A);
        check_val("t1_rises", ncap[0], 64'd8);
        check_val("t1_busy", nbusy[0], 64'd36);
        check_val("t1_cen_gap", ncenhi[0], 64'd2);
        check_val("t1_done", ndone[0], 64'd1);
        check_val("t1_first_rise", first_dly[0], 64'd2);
        check_val("t1_mosi_stable", nviol[0], 64'd0);

        // DIV=1 burst: keep_cs frame then back-to-back load on the done cycle
        clear_mon();
        data = 16'hF81F; len = 4'd15; dc = 1'b1; keep_cs = 1'b1; load[1] = 1'b1;
        cyc();
        load[1] = 1'b0;
        wait_done(1, 100);
        check_val("t2_done_a", ndone[1], 64'd1);
        nb1 = nbusy[1];
        check_val("t2_busy_a", nb1, 64'd33);
        data = 16'h07E0; keep_cs = 1'b0; load[1] = 1'b1;
        cyc();
        load[1] = 1'b0;
        check_val("t2_busy_b_start", busy[1], 64'd1);
        wait_done(1, 100);
        repeat (3) cyc();
        check_val("t2_busy_b", nbusy[1] - nb1, 64'd34);
        check_val("t2_bits", cap[1], 64'hF81F07E0);
        check_val("t2_rises", ncap[1], 64'd32);
        check_val("t2_cen_rise", ncenrise[1], 64'd1);
        check_val("t2_cen_gap", ncenhi[1], 64'd1);
        check_val("t2_done", ndone[1], 64'd2);
        check_val("t2_first_rise", first_dly[1], 64'd1);
        check_val("t2_mosi_stable", nviol[1], 64'd0);

        // Loads while busy, with changed data, must be ignored
        clear_mon();
        data = 16'h00C3; len = 4'd7; dc = 1'b1; keep_cs = 1'b0; load[0] = 1'b1;
        cyc();
        data = 16'h0055;
        repeat (20) cyc();
        load[0] = 1'b0;
        wait_done(0, 200);
        repeat (6) cyc();
        check_val("t3_bits", cap[0], 64'hC3);
        check_val("t3_rises", ncap[0], 64'd8);
        check_val("t3_done", ndone[0], 64'd1);
        check_val("t3_busy", nbusy[0], 64'd36);
        check_val("t3_dcn", dcn[0], 64'd1);

        // Reset in the third HIGH phase, then a clean frame
        clear_mon();
        data = 16'h00A5; len = 4'd7; dc = 1'b0; keep_cs = 1'b0; load[0] = 1'b1;
        cyc();
        load[0] = 1'b0;
        for (int i = 0; i < 100 && ncap[0] < 3; i++) cyc();
        check_val("t4_third_high", {63'd0, sck[0]} + 64'(ncap[0]), 64'd4);
        reset = 1'b1;
        #1;
        check_val("t4_abort", {60'd0, cen[0], sck[0], busy[0], done[0]}, 64'b1000);
        repeat (2) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check_val("t4_no_done", ndone[0], 64'd0);
        clear_mon();
        data = 16'h0096; load[0] = 1'b1;
        cyc();
        load[0] = 1'b0;
        wait_done(0, 200);
        repeat (3) cyc();
        check_val("t4_bits", cap[0], 64'h96);
        check_val("t4_rises", ncap[0], 64'd8);
        check_val("t4_done", ndone[0], 64'd1);
        check_val("t4_busy", nbusy[0], 64'd36);

        // Single-bit frame at DIV=3
        clear_mon();
        data = 16'h0001; len = 4'd0; dc = 1'b1; keep_cs = 1'b0; load[2] = 1'b1;
        cyc();
        load[2] = 1'b0;
        wait_done(2, 100);
        repeat (4) cyc();
        check_val("t5_bits", cap[2], 64'h1);
        check_val("t5_rises", ncap[2], 64'd1);
        check_val("t5_busy", nbusy[2], 64'd12);
        check_val("t5_done", ndone[2], 64'd1);
        check_val("t5_first_rise", first_dly[2], 64'd3);

        // 12-bit payload with len clamped from 15 to 11
        clear_mon();
        data = 16'hFA5C; len = 4'd15; dc = 1'b0; keep_cs = 1'b0; load[3] = 1'b1;
        cyc();
        load[3] = 1'b0;
        wait_done(3, 200);
        repeat (4) cyc();
        check_val("t6_bits", cap[3], 64'hA5C);
        check_val("t6_rises", ncap[3], 64'd12);
        check_val("t6_busy", nbusy[3], 64'd52);
        check_val("t6_done", ndone[3], 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
